scandoubler_ctrl: RTL
=====================

// Module: scandoubler_ctrl
// PURPOSE
//  Mode sequencer in front of the scandoubler. Measures input frame height (lines per vsync), locks onto a stable standard, then drives the scandoubler/hq2x/mono enables.
//  User requests are applied only at frame boundaries, with output blanking across each switch so the monitor never sees a half-switched frame.
//  Sits between the OSD/config registers and the scandoubler in the video path.
// PARAMETERS
//  LINES_MIN      240  minimum valid lines per frame (inclusive)
//  LINES_MAX      320  maximum valid lines per frame (inclusive)
//  STABLE_FRAMES  3    consecutive matching frames required to lock (1..15)
//  BLANK_FRAMES   2    frames blanked around a mode switch (1..15)
//  VCNT_W         10   line counter width; saturates at 2^VCNT_W-1
// PORTS
//  clk_sys     in   1       system clock
//  reset_n     in   1       synchronous active-low reset
//  ce_pix      in   1       pixel clock enable; hs_in/vs_in sampled only when high
//  hs_in       in   1       input hsync, active high
//  vs_in       in   1       input vsync, active high
//  req_sd      in   1       user request: scandoubler on
//  req_hq2x    in   1       user request: hq2x filter on
//  req_mono    in   1       user request: mono output
//  sd_en       out  1       scandoubler enable (0 = 15 kHz passthrough)
//  hq2x_en     out  1       to scandoubler hq2x input
//  mono_en     out  1       to scandoubler mono input
//  blank_out   out  1       force RGB to black
//  locked      out  1       input timing locked
// BEHAVIOUR
//  Reset (reset_n=0 at clk_sys edge): sd_en=0, hq2x_en=0, mono_en=0, blank_out=1, locked=0, FSM=UNLOCK, counters=0.
//  Edge detection: registered hs/vs updated on ce_pix. hs_rise = !hs_q & hs_in; vs_fall = vs_q & !vs_in; both qualified by ce_pix, 1-cycle pulses.
//  vcnt increments on hs_rise and saturates at all-ones. On vs_fall: fcnt=vcnt, vcnt<=0 (the same-cycle hs_rise is dropped).
//  Frame valid = LINES_MIN <= fcnt <= LINES_MAX. Frame match = |fcnt - ref_cnt| <= 1 (unsigned compare, no wrap).
//  FSM, evaluated only on vs_fall:
//   UNLOCK: outputs 0 and blank_out=0 (raw passthrough). A valid frame sets ref_cnt=fcnt and stab=1. Each further valid match increments stab.
//     A valid mismatch reloads ref_cnt and sets stab=1; an invalid frame clears stab.
//     stab==STABLE_FRAMES -> BLANK_IN with locked=1.
//   BLANK_IN: blank_out=1 and bcnt=0. Each vs_fall increments bcnt; bcnt==BLANK_FRAMES-1 -> APPLY.
//   APPLY: latch sd_en=req_sd, hq2x_en=req_hq2x&req_sd, mono_en=req_mono. Next vs_fall -> BLANK_OUT.
//   BLANK_OUT: blank_out stays 1 for BLANK_FRAMES frames, then RUN with blank_out=0.
//   RUN: if any req_* differs from its latched value -> BLANK_IN.
//  Lock loss, from any locked state, on an invalid or mismatched frame: same cycle -> UNLOCK; locked=0, enables=0, blank_out=0, stab=0.
//  Timeout: vcnt saturating while locked is treated as lock loss immediately, without waiting for vs_fall.
//  req_* changes during BLANK_IN/APPLY/BLANK_OUT are sampled at APPLY only. Later changes are caught in RUN.
//  All outputs are registered. Latency is 1 clk_sys after the qualifying vs_fall edge.
//  reset_n low mid-sequence returns to the reset values on the next clock.
// CONFIGURATION
//  SCANDBL_CTRL_MEASURE_EN defined: adds output meas_lines[VCNT_W-1:0] = fcnt of the last completed frame (reset 0).
//    Also adds meas_hlen[11:0] = ce_pix count between hs_rise pulses, latched at hs_rise and saturating at 12'hFFF. Both are for OSD display.
//  Undefined: neither port exists and the hlen counter logic is absent. Behaviour is otherwise identical.
// STRUCTURE
//  Package scandoubler_pkg: FSM state enum {UNLOCK, BLANK_IN, APPLY, BLANK_OUT, RUN} and the reset-value constants.
//  Sub-module sync_edge_det (registered ce-qualified rise/fall detector) is used twice, for hs and vs.
//  FSM, frame counter and comparator stay in this module.
// TESTING
//  1. 312-line frames, 3 frames, req_sd=1 -> locked=1 after 3rd vs_fall; blank_out high 2 frames; sd_en=1 at APPLY; blank_out=0 after 2 more frames.
//  2. Locked at 312; one 313-line frame then one 262-line frame -> lock held on 313; 262 drops locked/sd_en/blank_out to 0 one clk after vs_fall.
//  3. In RUN, toggle req_hq2x 0->1 mid-frame -> no output change before next vs_fall; then blank 2 frames, hq2x_en=1, blank 2 frames.
//  4. Locked, then vs_in held low for 1024 lines with VCNT_W=10 -> vcnt saturates, locked=0 immediately.
//  5. reset_n=0 during BLANK_OUT -> next clk: blank_out=1, all enables 0, locked=0; relock needs 3 fresh frames.
//  6. MEASURE_EN, 312 lines x 448 pixels -> meas_lines=312, meas_hlen=448 after the first full frame.

Source files
------------

// File: rtl/scandoubler_pkg.sv
// ============================================================================
// Module   : scandoubler_pkg
// Brief    : Shared state encoding and reset values for scandoubler_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scandoubler_pkg;

    localparam int C_STATE_W = 3;
    typedef logic [C_STATE_W-1:0] state_t;

    localparam logic [C_STATE_W-1:0] C_UNLOCK    = 3'd0;
    localparam logic [C_STATE_W-1:0] C_BLANK_IN  = 3'd1;
    localparam logic [C_STATE_W-1:0] C_APPLY     = 3'd2;
    localparam logic [C_STATE_W-1:0] C_BLANK_OUT = 3'd3;
    localparam logic [C_STATE_W-1:0] C_RUN       = 3'd4;

    localparam logic C_RST_SD_EN   = 1'b0;
    localparam logic C_RST_HQ2X_EN = 1'b0;
    localparam logic C_RST_MONO_EN = 1'b0;
    localparam logic C_RST_BLANK   = 1'b1;
    localparam logic C_RST_LOCKED  = 1'b0;

    localparam int          C_HLEN_W   = 12;
    localparam logic [11:0] C_HLEN_MAX = 12'hFFF;

endpackage

`default_nettype wire

// File: rtl/scandoubler_ctrl_sync_edge_det.sv
// ============================================================================
// Module   : sync_edge_det
// Brief    : ce-qualified single-cycle rise or fall detector on a sync input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_det #(
    parameter bit FALLING = 1'b0
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ce,
    input  logic sig_in,
    output logic pulse
);

    logic r_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            r_q <= 1'b0;
        else if (ce)
            r_q <= sig_in;
    end

    generate
        if (FALLING) begin : g_fall
            assign pulse = ce & r_q & ~sig_in;
        end else begin : g_rise
            assign pulse = ce & ~r_q & sig_in;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/scandoubler_ctrl.sv
// ============================================================================
// Module   : scandoubler_ctrl
// Brief    : Frame-height lock and blanked mode sequencer for the scandoubler.
//            Optional SCANDBL_CTRL_MEASURE_EN adds meas_lines / meas_hlen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scandoubler_ctrl
    import scandoubler_pkg::*;
#(
    parameter int LINES_MIN     = 240,
    parameter int LINES_MAX     = 320,
    parameter int STABLE_FRAMES = 3,
    parameter int BLANK_FRAMES  = 2,
    parameter int VCNT_W        = 10
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              req_sd,
    input  logic              req_hq2x,
    input  logic              req_mono,
    output logic              sd_en,
    output logic              hq2x_en,
    output logic              mono_en,
    output logic              blank_out,
    output logic              locked
`ifdef SCANDBL_CTRL_MEASURE_EN
    ,
    output logic [VCNT_W-1:0] meas_lines,
    output logic [11:0]       meas_hlen
`endif
);

    localparam logic [VCNT_W-1:0] c_vmax      = {VCNT_W{1'b1}};
    localparam logic [VCNT_W-1:0] c_lines_min = VCNT_W'(LINES_MIN);
    localparam logic [VCNT_W-1:0] c_lines_max = VCNT_W'(LINES_MAX);
    localparam logic [VCNT_W-1:0] c_one       = VCNT_W'(1);
    localparam logic [3:0]        c_stable    = 4'(STABLE_FRAMES);
    localparam logic [3:0]        c_blank_end = 4'(BLANK_FRAMES - 1);

    logic              w_hs_rise;
    logic              w_vs_fall;
    logic              w_valid;
    logic              w_match;
    logic              w_reload;
    logic [VCNT_W-1:0] w_diff;
    logic [3:0]        w_stab_next;

    state_t            r_state;
    logic [VCNT_W-1:0] r_vcnt;
    logic [VCNT_W-1:0] r_ref;
    logic [3:0]        r_stab;
    logic [3:0]        r_bcnt;
    logic              r_req_sd;
    logic              r_req_hq2x;
    logic              r_req_mono;
    logic              r_sd_en;
    logic              r_hq2x_en;
    logic              r_mono_en;
    logic              r_blank;
    logic              r_locked;

    sync_edge_det #(.FALLING(1'b0)) u_hs_det (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce_pix),
        .sig_in  (hs_in),
        .pulse   (w_hs_rise)
    );

    sync_edge_det #(.FALLING(1'b1)) u_vs_det (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce_pix),
        .sig_in  (vs_in),
        .pulse   (w_vs_fall)
    );

    // r_vcnt holds the just-finished frame height on the vs_fall cycle.
    always_comb begin
        w_valid     = (r_vcnt >= c_lines_min) && (r_vcnt <= c_lines_max);
        w_diff      = (r_vcnt >= r_ref) ? (r_vcnt - r_ref) : (r_ref - r_vcnt);
        w_match     = (w_diff <= c_one);
        w_reload    = w_valid && !((r_stab != 4'd0) && w_match);
        w_stab_next = 4'd0;
        if (w_valid)
            w_stab_next = w_reload ? 4'd1 : (r_stab + 4'd1);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state    <= C_UNLOCK;
            r_vcnt     <= '0;
            r_ref      <= '0;
            r_stab     <= '0;
            r_bcnt     <= '0;
            r_req_sd   <= 1'b0;
            r_req_hq2x <= 1'b0;
            r_req_mono <= 1'b0;
            r_sd_en    <= C_RST_SD_EN;
            r_hq2x_en  <= C_RST_HQ2X_EN;
            r_mono_en  <= C_RST_MONO_EN;
            r_blank    <= C_RST_BLANK;
            r_locked   <= C_RST_LOCKED;
        end else begin
            if (w_vs_fall)
                r_vcnt <= '0;
            else if (w_hs_rise && (r_vcnt != c_vmax))
                r_vcnt <= r_vcnt + 1'b1;

            // A stuck vsync saturates the line counter; drop lock without waiting.
            if (r_locked && ((r_vcnt == c_vmax) || (w_vs_fall && !(w_valid && w_match)))) begin
                r_state   <= C_UNLOCK;
                r_locked  <= 1'b0;
                r_sd_en   <= 1'b0;
                r_hq2x_en <= 1'b0;
                r_mono_en <= 1'b0;
                r_blank   <= 1'b0;
                r_stab    <= '0;
            end else if (w_vs_fall) begin
                case (r_state)
                    C_UNLOCK: begin
                        r_blank <= 1'b0;
                        r_stab  <= w_stab_next;
                        if (w_reload)
                            r_ref <= r_vcnt;
                        if (w_stab_next == c_stable) begin
                            r_state  <= C_BLANK_IN;
                            r_locked <= 1'b1;
                            r_blank  <= 1'b1;
                            r_bcnt   <= '0;
                        end
                    end
                    C_BLANK_IN: begin
                        if (r_bcnt == c_blank_end) begin
                            r_state    <= C_APPLY;
                            r_sd_en    <= req_sd;
                            r_hq2x_en  <= req_hq2x & req_sd;
                            r_mono_en  <= req_mono;
                            r_req_sd   <= req_sd;
                            r_req_hq2x <= req_hq2x;
                            r_req_mono <= req_mono;
                        end else begin
                            r_bcnt <= r_bcnt + 4'd1;
                        end
                    end
                    C_APPLY: begin
                        r_state <= C_BLANK_OUT;
                        r_bcnt  <= '0;
                    end
                    C_BLANK_OUT: begin
                        if (r_bcnt == c_blank_end) begin
                            r_state <= C_RUN;
                            r_blank <= 1'b0;
                        end else begin
                            r_bcnt <= r_bcnt + 4'd1;
                        end
                    end
                    C_RUN: begin
                        if ((req_sd != r_req_sd) || (req_hq2x != r_req_hq2x) ||
                            (req_mono != r_req_mono)) begin
                            r_state <= C_BLANK_IN;
                            r_blank <= 1'b1;
                            r_bcnt  <= '0;
                        end
                    end
                    default: r_state <= C_UNLOCK;
                endcase
            end
        end
    end

    assign sd_en     = r_sd_en;
    assign hq2x_en   = r_hq2x_en;
    assign mono_en   = r_mono_en;
    assign blank_out = r_blank;
    assign locked    = r_locked;

`ifdef SCANDBL_CTRL_MEASURE_EN
    logic [VCNT_W-1:0]   r_meas_lines;
    logic [C_HLEN_W-1:0] r_meas_hlen;
    logic [C_HLEN_W-1:0] r_hcnt;

    // r_hcnt counts ce_pix cycles since the last hs_rise, that cycle excluded.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_meas_lines <= '0;
            r_meas_hlen  <= '0;
            r_hcnt       <= '0;
        end else begin
            if (w_vs_fall)
                r_meas_lines <= r_vcnt;
            if (w_hs_rise) begin
                r_meas_hlen <= (r_hcnt == C_HLEN_MAX) ? C_HLEN_MAX : (r_hcnt + 1'b1);
                r_hcnt      <= '0;
            end else if (ce_pix && (r_hcnt != C_HLEN_MAX)) begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    assign meas_lines = r_meas_lines;
    assign meas_hlen  = r_meas_hlen;
`endif

endmodule

`default_nettype wire
